irq_trap_ctrl: RTL and testbench

//   Machine-mode interrupt/trap controller; direct consumer of the memory-mapped timer's timer_interrupt.

---
 rtl/irq_trap_ctrl_pkg.sv | 36 +++
 rtl/irq_trap_ctrl_if.sv | 16 +
 rtl/irq_trap_ctrl_csr_file.sv | 116 +++++++++++
 rtl/irq_trap_ctrl.sv | 128 ++++++++++++
 tb/tb_irq_trap_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_trap_ctrl_pkg.sv
// rtl/irq_trap_ctrl_pkg.sv - shared constants, FSM states and helpers for the trap controller
// Purpose: CSR addresses, mstatus/mie/mip bit indices, FSM state encoding and
//          the interrupt-cause builder shared by irq_trap_ctrl and irq_csr_file.
package irq_trap_ctrl_pkg;

  localparam int DEF_XLEN = 32;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MIE_MTIE_BIT     = 7;
  localparam int MIP_MTIP_BIT     = 7;
  localparam int MCAUSE_IRQ_BIT   = DEF_XLEN - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } irq_state_e;

  // mcause value for an interrupt: exception code with the interrupt flag set.
  function automatic logic [DEF_XLEN-1:0] irq_cause(input int unsigned code);
    logic [DEF_XLEN-1:0] c;
    c = DEF_XLEN'(code);
    c[MCAUSE_IRQ_BIT] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/irq_trap_ctrl_if.sv
// rtl/irq_trap_ctrl_if.sv - CSR access bus between commit stage and trap controller
// Purpose: groups the CSR read/write signals.
// Signals: csr_we (write strobe), csr_addr[11:0], csr_wdata[XLEN-1:0],
//          csr_rdata[XLEN-1:0] (combinational read, 0 when unmapped).
// Modports: master = commit stage side, slave = controller side.
interface irq_trap_ctrl_if #(
  parameter int XLEN = irq_trap_ctrl_pkg::DEF_XLEN
);
  logic            csr_we;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;

  modport master (output csr_we, output csr_addr, output csr_wdata, input csr_rdata);
  modport slave  (input csr_we, input csr_addr, input csr_wdata, output csr_rdata);
endinterface

// File: rtl/irq_trap_ctrl_csr_file.sv
// rtl/irq_trap_ctrl_csr_file.sv - machine-mode CSR storage and read mux
// Purpose: holds mstatus.MIE/MPIE, mie.MTIE, mtvec, mepc, mcause; exposes mip.MTIP.
// Ports: clk, rst (async, active-high); csr_we/csr_addr/csr_wdata -> csr_rdata;
//        irq_q (sampled MTIP); trap_set/trap_pc and mret_set (trap-side updates,
//        which beat a same-cycle CSR write); mstatus_mie, mie_mtie, mtvec, mepc out.
// Config: TRAP_VECTORED_EN makes mtvec[1:0] hold mode 00/01; otherwise reads 0.
module irq_csr_file
  import irq_trap_ctrl_pkg::*;
#(
  parameter int              XLEN        = DEF_XLEN,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter int unsigned     TIMER_CAUSE = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  input  logic            irq_q,
  input  logic            trap_set,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret_set,
  output logic            mstatus_mie,
  output logic            mie_mtie,
  output logic [XLEN-1:0] mtvec,
  output logic [XLEN-1:0] mepc
);

  localparam logic [XLEN-1:0] LOW2_MASK = ~XLEN'(3);

  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic            mie_mtie_q, mie_mtie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtvec_mode;

`ifdef TRAP_VECTORED_EN
  // Only direct (00) and vectored (01) are legal; anything else collapses to direct.
  assign mtvec_mode = (csr_wdata[1:0] == 2'b01) ? XLEN'(1) : '0;
`else
  assign mtvec_mode = '0;
`endif

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_mtie_d     = mie_mtie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;

    if (csr_we && csr_addr == CSR_MIE)   mie_mtie_d = csr_wdata[MIE_MTIE_BIT];
    if (csr_we && csr_addr == CSR_MTVEC) mtvec_d    = (csr_wdata & LOW2_MASK) | mtvec_mode;

    if (trap_set) begin
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      mepc_d         = trap_pc & LOW2_MASK;
      mcause_d       = XLEN'(irq_cause(TIMER_CAUSE));
    end else begin
      if (mret_set) begin
        mstatus_mie_d  = mstatus_mpie_q;
        mstatus_mpie_d = 1'b1;
      end else if (csr_we && csr_addr == CSR_MSTATUS) begin
        mstatus_mie_d  = csr_wdata[MSTATUS_MIE_BIT];
        mstatus_mpie_d = csr_wdata[MSTATUS_MPIE_BIT];
      end
      if (csr_we && csr_addr == CSR_MEPC)   mepc_d   = csr_wdata & LOW2_MASK;
      if (csr_we && csr_addr == CSR_MCAUSE) mcause_d = csr_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_mtie_q     <= 1'b0;
      mtvec_q        <= MTVEC_RESET & LOW2_MASK;
      mepc_q         <= '0;
      mcause_q       <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_mtie_q     <= mie_mtie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[12:11]            = 2'b11;  // MPP: machine mode only
        csr_rdata[MSTATUS_MIE_BIT]  = mstatus_mie_q;
        csr_rdata[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
      end
      CSR_MIE:    csr_rdata[MIE_MTIE_BIT] = mie_mtie_q;
      CSR_MTVEC:  csr_rdata = mtvec_q;
      CSR_MEPC:   csr_rdata = mepc_q;
      CSR_MCAUSE: csr_rdata = mcause_q;
      CSR_MIP:    csr_rdata[MIP_MTIP_BIT] = irq_q;
      default:    csr_rdata = '0;
    endcase
  end

  assign mstatus_mie = mstatus_mie_q;
  assign mie_mtie    = mie_mtie_q;
  assign mtvec       = mtvec_q;
  assign mepc        = mepc_q;

endmodule

// File: rtl/irq_trap_ctrl.sv
// rtl/irq_trap_ctrl.sv - machine timer interrupt / mret redirect controller
// Purpose: gates sampled MTIP with MIE/MTIE, waits for a precise commit boundary,
//          then requests flush + redirect to the handler; also redirects on mret.
// Ports: clk, rst (async, active-high); timer_irq_in; csr_bus (slave CSR bus);
//        boundary_in, boundary_pc_in, mret_commit, flush_done in;
//        redirect_vld (1-cycle pulse), redirect_pc, irq_busy out.
// Config: TRAP_VECTORED_EN enables vectored mtvec (handler = base + 4*cause).
module irq_trap_ctrl
  import irq_trap_ctrl_pkg::*;
#(
  parameter int              XLEN        = DEF_XLEN,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter int unsigned     TIMER_CAUSE = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            timer_irq_in,
  irq_trap_ctrl_if.slave  csr_bus,
  input  logic            boundary_in,
  input  logic [XLEN-1:0] boundary_pc_in,
  input  logic            mret_commit,
  input  logic            flush_done,
  output logic            redirect_vld,
  output logic [XLEN-1:0] redirect_pc,
  output logic            irq_busy
);

  logic            irq_q, irq_d;
  irq_state_e      state_q, state_d;
  logic            redirect_vld_q, redirect_vld_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            irq_busy_q, irq_busy_d;

  logic            mstatus_mie, mie_mtie, eligible;
  logic            trap_set, mret_set, csr_we_eff;
  logic [XLEN-1:0] mtvec, mepc, handler_pc;

  assign irq_d    = timer_irq_in;
  assign eligible = irq_q & mstatus_mie & mie_mtie;
  // mret is only honoured while the pipeline is live; it pre-empts a pending trap.
  assign mret_set = mret_commit && (state_q == ST_IDLE || state_q == ST_PEND);
  assign trap_set = (state_q == ST_PEND) && !mret_commit && eligible && boundary_in;
  // Pipeline is empty while draining, so stray CSR strobes are dropped.
  assign csr_we_eff = csr_bus.csr_we && (state_q != ST_DRAIN);

`ifdef TRAP_VECTORED_EN
  assign handler_pc = (mtvec[1:0] == 2'b01) ?
                      ((mtvec & ~XLEN'(3)) + XLEN'(4 * TIMER_CAUSE)) : mtvec;
`else
  assign handler_pc = mtvec;
`endif

  irq_csr_file #(
    .XLEN        (XLEN),
    .MTVEC_RESET (MTVEC_RESET),
    .TIMER_CAUSE (TIMER_CAUSE)
  ) u_csr (
    .clk         (clk),
    .rst         (rst),
    .csr_we      (csr_we_eff),
    .csr_addr    (csr_bus.csr_addr),
    .csr_wdata   (csr_bus.csr_wdata),
    .csr_rdata   (csr_bus.csr_rdata),
    .irq_q       (irq_q),
    .trap_set    (trap_set),
    .trap_pc     (boundary_pc_in),
    .mret_set    (mret_set),
    .mstatus_mie (mstatus_mie),
    .mie_mtie    (mie_mtie),
    .mtvec       (mtvec),
    .mepc        (mepc)
  );

  always_comb begin
    state_d        = state_q;
    redirect_vld_d = 1'b0;
    redirect_pc_d  = redirect_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (mret_set) begin
          state_d        = ST_DRAIN;
          redirect_vld_d = 1'b1;
          redirect_pc_d  = mepc;
        end else if (eligible) begin
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (mret_set) begin
          state_d        = ST_DRAIN;
          redirect_vld_d = 1'b1;
          redirect_pc_d  = mepc;
        end else if (!eligible) begin
          state_d = ST_IDLE;
        end else if (trap_set) begin
          state_d        = ST_FLUSH;
          redirect_vld_d = 1'b1;
          redirect_pc_d  = handler_pc;
        end
      end
      ST_FLUSH: state_d = ST_DRAIN;
      ST_DRAIN: if (flush_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    irq_busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      irq_q          <= 1'b0;
      redirect_vld_q <= 1'b0;
      redirect_pc_q  <= '0;
      irq_busy_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      irq_q          <= irq_d;
      redirect_vld_q <= redirect_vld_d;
      redirect_pc_q  <= redirect_pc_d;
      irq_busy_q     <= irq_busy_d;
    end
  end

  assign redirect_vld = redirect_vld_q;
  assign redirect_pc  = redirect_pc_q;
  assign irq_busy     = irq_busy_q;

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// tb/tb_irq_trap_ctrl.sv - directed self-checking bench for irq_trap_ctrl
module tb_irq_trap_ctrl;

  logic        clk;
  logic        rst;
  logic        timer_irq_in;
  logic        boundary_in;
  logic [31:0] boundary_pc_in;
  logic        mret_commit;
  logic        flush_done;
  logic        redirect_vld;
  logic [31:0] redirect_pc;
  logic        irq_busy;

  irq_trap_ctrl_if #(.XLEN(32)) csr_bus ();

  irq_trap_ctrl #(
    .XLEN        (32),
    .MTVEC_RESET (32'h0),
    .TIMER_CAUSE (7)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .timer_irq_in   (timer_irq_in),
    .csr_bus        (csr_bus),
    .boundary_in    (boundary_in),
    .boundary_pc_in (boundary_pc_in),
    .mret_commit    (mret_commit),
    .flush_done     (flush_done),
    .redirect_vld   (redirect_vld),
    .redirect_pc    (redirect_pc),
    .irq_busy       (irq_busy)
  );

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;

  int n_cmp = 0;
  int n_err = 0;
  int n_redirects = 0;
  logic [31:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_bus.csr_we    = 1'b1;
    csr_bus.csr_addr  = addr;
    csr_bus.csr_wdata = data;
    tick();
    csr_bus.csr_we    = 1'b0;
  endtask

  task automatic csr_check(input string tag, input logic [11:0] addr, input logic [31:0] expv);
    csr_bus.csr_addr = addr;
    #1;
    check(tag, csr_bus.csr_rdata, expv);
  endtask

  task automatic wait_redirects(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (n_redirects >= target) break;
    end
    check("redirect_count", 32'(n_redirects), 32'(target));
  endtask

  // Scoreboard consumer: every redirect pulse must match the next queued target.
  always @(negedge clk) begin
    if (!rst && redirect_vld) begin
      n_redirects++;
      if (exp_q.size() == 0) check("redirect_unexpected", 32'(redirect_vld), 32'd0);
      else check("redirect_pc", redirect_pc, exp_q.pop_front());
    end
  end

  initial begin
    logic busy_seen;
    rst = 1'b1;
    timer_irq_in = 1'b0;
    boundary_in = 1'b0;
    boundary_pc_in = 32'h0;
    mret_commit = 1'b0;
    flush_done = 1'b0;
    csr_bus.csr_we = 1'b0;
    csr_bus.csr_addr = 12'h0;
    csr_bus.csr_wdata = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_redirect_vld", 32'(redirect_vld), 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'h0);
    check("rst_irq_busy", 32'(irq_busy), 32'd0);
    csr_check("rst_mstatus", A_MSTATUS, 32'h1800);
    csr_check("rst_mtvec", A_MTVEC, 32'h0);
    csr_check("rst_mcause", A_MCAUSE, 32'h0);
    tick();
    rst = 1'b0;

    // 1: timer trap at a boundary
    timer_irq_in = 1'b1;
    csr_write(A_MTVEC, 32'h100);
    csr_write(A_MIE, 32'h80);
    csr_write(A_MSTATUS, 32'h8);
    exp_q.push_back(32'h100);
    boundary_in = 1'b1;
    boundary_pc_in = 32'h40;
    wait_redirects(1, 10);
    boundary_in = 1'b0;
    timer_irq_in = 1'b0;
    @(negedge clk);
    check("t1_busy_drain", 32'(irq_busy), 32'd1);
    check("t1_vld_one_cycle", 32'(redirect_vld), 32'd0);
    check("t1_pc_held", redirect_pc, 32'h100);
    flush_done = 1'b1;
    tick();
    flush_done = 1'b0;
    @(negedge clk);
    check("t1_busy_idle", 32'(irq_busy), 32'd0);
    csr_check("t1_mepc", A_MEPC, 32'h40);
    csr_check("t1_mcause", A_MCAUSE, 32'h80000007);
    csr_check("t1_mstatus", A_MSTATUS, 32'h1880);

    // 2: MIE clear masks the interrupt
    timer_irq_in = 1'b1;
    busy_seen = 1'b0;
    repeat (50) begin
      tick();
      if (irq_busy) busy_seen = 1'b1;
    end
    check("t2_busy_never", 32'(busy_seen), 32'd0);
    check("t2_no_redirect", 32'(n_redirects), 32'd1);
    csr_check("t2_mip", A_MIP, 32'h80);
    timer_irq_in = 1'b0;
    repeat (2) tick();
    csr_check("t2_mip_clear", A_MIP, 32'h0);

    // 3: interrupt withdrawn while pending
    timer_irq_in = 1'b1;
    csr_write(A_MSTATUS, 32'h8);
    repeat (2) tick();
    check("t3_busy_pend", 32'(irq_busy), 32'd1);
    timer_irq_in = 1'b0;
    repeat (3) tick();
    check("t3_busy_idle", 32'(irq_busy), 32'd0);
    boundary_in = 1'b1;
    boundary_pc_in = 32'h50;
    repeat (3) tick();
    boundary_in = 1'b0;
    check("t3_no_redirect", 32'(n_redirects), 32'd1);

    // 4: mret beats a same-cycle trap; also low-bit masking and unmapped CSR
    csr_write(A_MEPC, 32'h47);
    csr_check("t4_mepc_align", A_MEPC, 32'h44);
    csr_write(12'h7C0, 32'hDEAD_BEEF);
    csr_check("t4_unmapped", 12'h7C0, 32'h0);
    csr_write(A_MSTATUS, 32'h88);
    timer_irq_in = 1'b1;
    repeat (2) tick();
    check("t4_busy_pend", 32'(irq_busy), 32'd1);
    exp_q.push_back(32'h44);
    boundary_in = 1'b1;
    boundary_pc_in = 32'h80;
    mret_commit = 1'b1;
    wait_redirects(2, 10);
    mret_commit = 1'b0;
    boundary_in = 1'b0;
    timer_irq_in = 1'b0;
    csr_check("t4_mstatus", A_MSTATUS, 32'h1888);
    csr_check("t4_mcause_kept", A_MCAUSE, 32'h80000007);
    csr_check("t4_mepc_kept", A_MEPC, 32'h44);
    flush_done = 1'b1;
    tick();
    flush_done = 1'b0;
    repeat (2) tick();
    check("t4_busy_idle", 32'(irq_busy), 32'd0);

    // 5: reset while draining
    timer_irq_in = 1'b1;
    repeat (2) tick();
    exp_q.push_back(32'h100);
    boundary_in = 1'b1;
    boundary_pc_in = 32'h60;
    wait_redirects(3, 10);
    boundary_in = 1'b0;
    tick();
    check("t5_busy_drain", 32'(irq_busy), 32'd1);
    rst = 1'b1;
    timer_irq_in = 1'b0;
    #1;
    check("t5_rst_vld", 32'(redirect_vld), 32'd0);
    check("t5_rst_pc", redirect_pc, 32'h0);
    check("t5_rst_busy", 32'(irq_busy), 32'd0);
    csr_check("t5_rst_mstatus", A_MSTATUS, 32'h1800);
    tick();
    rst = 1'b0;
    flush_done = 1'b1;
    tick();
    flush_done = 1'b0;
    tick();
    check("t5_busy_after", 32'(irq_busy), 32'd0);
    check("t5_redirects", 32'(n_redirects), 32'd3);

    // 6: mtvec mode handling
    timer_irq_in = 1'b1;
`ifdef TRAP_VECTORED_EN
    csr_write(A_MTVEC, 32'h203);
    csr_check("t6_mtvec_illegal_mode", A_MTVEC, 32'h200);
    csr_write(A_MTVEC, 32'h201);
    csr_check("t6_mtvec", A_MTVEC, 32'h201);
    exp_q.push_back(32'h21C);
`else
    csr_write(A_MTVEC, 32'h201);
    csr_check("t6_mtvec", A_MTVEC, 32'h200);
    exp_q.push_back(32'h200);
`endif
    csr_write(A_MIE, 32'h80);
    csr_write(A_MSTATUS, 32'h8);
    boundary_in = 1'b1;
    boundary_pc_in = 32'h70;
    wait_redirects(4, 10);
    boundary_in = 1'b0;
    timer_irq_in = 1'b0;
    tick();
    flush_done = 1'b1;
    tick();
    flush_done = 1'b0;
    csr_check("t6_mepc", A_MEPC, 32'h70);
    csr_check("t6_mcause", A_MCAUSE, 32'h80000007);
    check("t6_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
